// File: rtl/tl_phase_scheduler.sv
// Two-direction traffic-light phase scheduler with pedestrian walk phase.
// Every phase runs on a single 8-bit timer that is cleared when the phase is entered.
module tl_phase_scheduler #(
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW_T  = 4,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 8
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       req_ns,
    input  logic       req_we,
    input  logic       ped_req,
    output logic       RED_NS,
    output logic       YELLOW_NS,
    output logic       GREEN_NS,
    output logic       RED_WE,
    output logic       YELLOW_WE,
    output logic       GREEN_WE,
    output logic       WALK,
    output logic       ped_pending,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        WE_GREEN  = 3'd3,
        WE_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_WE = 1'b1;

    localparam logic [7:0] MIN_M1  = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_M1  = 8'(MAX_GREEN - 1);
    localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
    localparam logic [7:0] AR_M1   = 8'(ALL_RED_T - 1);
    localparam logic [7:0] WALK_M1 = 8'(WALK_T - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       last_dir_q, last_dir_d;
    logic       ped_pending_q, ped_pending_d;
    state_t     next_green;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= ALL_RED;
            timer_q       <= 8'd0;
            last_dir_q    <= DIR_WE;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_dir_q    <= last_dir_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Greens alternate: the next one served is always opposite the last one.
    assign next_green = (last_dir_q == DIR_WE) ? NS_GREEN : WE_GREEN;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + 8'd1;
        last_dir_d    = last_dir_q;
        ped_pending_d = ped_pending_q | ped_req;

        case (state_q)
            ALL_RED: begin
                if (timer_q == AR_M1) begin
                    timer_d = 8'd0;
                    if (ped_pending_q) begin
                        state_d       = PED_WALK;
                        ped_pending_d = 1'b0;
                    end else begin
                        state_d    = next_green;
                        last_dir_d = ~last_dir_q;
                    end
                end
            end
            NS_GREEN: begin
                if (timer_q == MAX_M1) timer_d = timer_q;
                if ((timer_q >= MIN_M1) && (req_we || ped_pending_q) &&
                    (!req_ns || (timer_q == MAX_M1))) begin
                    state_d = NS_YELLOW;
                    timer_d = 8'd0;
                end
            end
            WE_GREEN: begin
                if (timer_q == MAX_M1) timer_d = timer_q;
                if ((timer_q >= MIN_M1) && (req_ns || ped_pending_q) &&
                    (!req_we || (timer_q == MAX_M1))) begin
                    state_d = WE_YELLOW;
                    timer_d = 8'd0;
                end
            end
            NS_YELLOW, WE_YELLOW: begin
                if (timer_q == YEL_M1) begin
                    state_d = ALL_RED;
                    timer_d = 8'd0;
                end
            end
            PED_WALK: begin
                if (timer_q == WALK_M1) begin
                    state_d    = next_green;
                    last_dir_d = ~last_dir_q;
                    timer_d    = 8'd0;
                end
            end
            default: begin
                state_d = ALL_RED;
                timer_d = 8'd0;
            end
        endcase
    end

    // Lamps are a pure decode of the state register.
    always_comb begin
        RED_NS    = 1'b1;
        YELLOW_NS = 1'b0;
        GREEN_NS  = 1'b0;
        RED_WE    = 1'b1;
        YELLOW_WE = 1'b0;
        GREEN_WE  = 1'b0;
        WALK      = 1'b0;
        case (state_q)
            NS_GREEN: begin
                RED_NS   = 1'b0;
                GREEN_NS = 1'b1;
            end
            NS_YELLOW: begin
                RED_NS    = 1'b0;
                YELLOW_NS = 1'b1;
            end
            WE_GREEN: begin
                RED_WE   = 1'b0;
                GREEN_WE = 1'b1;
            end
            WE_YELLOW: begin
                RED_WE    = 1'b0;
                YELLOW_WE = 1'b1;
            end
            PED_WALK: WALK = 1'b1;
            default: ;
        endcase
    end

    assign ped_pending = ped_pending_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed bench for tl_phase_scheduler: per-cycle lamp patterns are queued
// from hand-computed phase lengths and compared on the falling clock edge.
module tb_tl_phase_scheduler;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       req_ns = 1'b0;
    logic       req_we = 1'b0;
    logic       ped_req = 1'b0;
    logic       RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE, GREEN_WE, WALK;
    logic       ped_pending;
    logic [2:0] state_dbg;
    logic [6:0] lamps;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_idx  = 0;

    // {RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE, GREEN_WE, WALK}
    localparam logic [6:0] P_AR  = 7'b1001000;
    localparam logic [6:0] P_NSG = 7'b0011000;
    localparam logic [6:0] P_NSY = 7'b0101000;
    localparam logic [6:0] P_WEG = 7'b1000010;
    localparam logic [6:0] P_WEY = 7'b1000100;
    localparam logic [6:0] P_PED = 7'b1001001;

    logic [6:0] exp_q[$];

    tl_phase_scheduler dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .req_ns     (req_ns),
        .req_we     (req_we),
        .ped_req    (ped_req),
        .RED_NS     (RED_NS),
        .YELLOW_NS  (YELLOW_NS),
        .GREEN_NS   (GREEN_NS),
        .RED_WE     (RED_WE),
        .YELLOW_WE  (YELLOW_WE),
        .GREEN_WE   (GREEN_WE),
        .WALK       (WALK),
        .ped_pending(ped_pending),
        .state_dbg  (state_dbg)
    );

    assign lamps = {RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE, GREEN_WE, WALK};

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_phase(input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pat);
    endtask

    // Called on a falling edge: compare one cycle, then advance one cycle.
    task automatic run_n(input string tag, input int n);
        logic [6:0] exp;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s_sb_empty", tag), 1, 0);
                exp = P_AR;
            end else begin
                exp = exp_q.pop_front();
            end
            check($sformatf("%s[%0d]", tag, cyc_idx), int'(lamps), int'(exp));
            check($sformatf("%s_ns_one[%0d]", tag, cyc_idx), $countones(lamps[6:4]), 1);
            check($sformatf("%s_we_one[%0d]", tag, cyc_idx), $countones(lamps[3:1]), 1);
            cyc_idx++;
            @(negedge clk);
        end
    endtask

    task automatic run_all(input string tag);
        run_n(tag, exp_q.size());
    endtask

    // Called on a falling edge: asserts clear_n between edges and checks the
    // effect before the next rising edge. Leaves clear_n low.
    task automatic apply_reset(input string tag);
        #2 clear_n = 1'b0;
        #1;
        check({tag, "_lamps"}, int'(lamps), int'(P_AR));
        check({tag, "_pending"}, int'(ped_pending), 0);
        check({tag, "_state"}, int'(state_dbg), 0);
        req_ns  = 1'b0;
        req_we  = 1'b0;
        ped_req = 1'b0;
        exp_q.delete();
        cyc_idx = 0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("init_lamps", int'(lamps), int'(P_AR));
        check("init_pending", int'(ped_pending), 0);
        check("init_state", int'(state_dbg), 0);

        // reset release with no demand: 2 all-red then NS green held
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        push_phase(P_NSG, 110);
        run_all("idle");

        // WE demand from NS green cycle 0: minimum green then hand-over
        apply_reset("rst2");
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        run_all("wd_ar");
        req_we = 1'b1;
        push_phase(P_NSG, 10);
        push_phase(P_NSY, 4);
        push_phase(P_AR, 2);
        push_phase(P_WEG, 5);
        run_all("we_demand");

        // both directions demanding: max green alternation
        apply_reset("rst3");
        req_ns  = 1'b1;
        req_we  = 1'b1;
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        push_phase(P_NSG, 30);
        push_phase(P_NSY, 4);
        push_phase(P_AR, 2);
        push_phase(P_WEG, 30);
        push_phase(P_WEY, 4);
        push_phase(P_AR, 2);
        push_phase(P_NSG, 30);
        push_phase(P_NSY, 1);
        run_all("both");

        // pedestrian pulse during WE green, no vehicle demand
        apply_reset("rst4");
        req_we  = 1'b1;
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        push_phase(P_NSG, 10);
        push_phase(P_NSY, 4);
        push_phase(P_AR, 2);
        run_all("ped_pre");
        req_we = 1'b0;
        push_phase(P_WEG, 3);
        run_all("ped_weg_a");
        ped_req = 1'b1;
        push_phase(P_WEG, 1);
        run_all("ped_pulse");
        ped_req = 1'b0;
        check("ped_latched", int'(ped_pending), 1);
        push_phase(P_WEG, 6);
        push_phase(P_WEY, 4);
        push_phase(P_AR, 1);
        run_all("ped_exit");
        check("ped_still_pending", int'(ped_pending), 1);
        ped_req = 1'b1;
        push_phase(P_AR, 1);
        run_all("ped_ar_last");
        ped_req = 1'b0;
        check("ped_clr_wins", int'(ped_pending), 0);
        push_phase(P_PED, 8);
        push_phase(P_NSG, 20);
        run_all("ped_walk");
        check("ped_served", int'(ped_pending), 0);

        // asynchronous clear in the middle of NS yellow with a pending walk
        apply_reset("rst5");
        req_we  = 1'b1;
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        push_phase(P_NSG, 2);
        run_all("my_a");
        ped_req = 1'b1;
        push_phase(P_NSG, 1);
        run_all("my_pulse");
        ped_req = 1'b0;
        push_phase(P_NSG, 7);
        push_phase(P_NSY, 2);
        run_all("my_b");
        check("my_pre_lamps", int'(lamps), int'(P_NSY));
        check("my_pre_pending", int'(ped_pending), 1);
        apply_reset("mid_yellow_clr");

        // walk request held through the walk: second walk after next green
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        run_all("rw_ar");
        ped_req = 1'b1;
        push_phase(P_NSG, 1);
        run_all("rw_pulse");
        ped_req = 1'b0;
        push_phase(P_NSG, 9);
        push_phase(P_NSY, 4);
        push_phase(P_AR, 2);
        run_all("rw_first");
        ped_req = 1'b1;
        push_phase(P_PED, 8);
        run_all("rw_walk1");
        ped_req = 1'b0;
        check("rw_rearmed", int'(ped_pending), 1);
        push_phase(P_WEG, 10);
        push_phase(P_WEY, 4);
        push_phase(P_AR, 2);
        push_phase(P_PED, 3);
        run_all("rw_walk2");
        check("rw_walk2_pending", int'(ped_pending), 0);
        apply_reset("walk_clr");

        // after reset the first green is NS again
        clear_n = 1'b1;
        push_phase(P_AR, 2);
        push_phase(P_NSG, 10);
        run_all("post_walk_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tl_phase_scheduler.md
TL_PHASE_SCHEDULER -- requirements
Module: tl_phase_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 10, the minimum green duration in cycles.
REQ-002 The block SHALL have parameter MAX_GREEN, default 30, the green duration after which the phase yields to a waiting demand.
REQ-003 The block SHALL have parameter YELLOW_T, default 4, the yellow duration in cycles.
REQ-004 The block SHALL have parameter ALL_RED_T, default 2, the all-red clearance duration in cycles.
REQ-005 The block SHALL have parameter WALK_T, default 8, the pedestrian walk duration in cycles.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-007 The block SHALL have port clear_n, input, 1 bit, the asynchronous active-low reset.
REQ-008 The block SHALL have ports req_ns and req_we, input, 1 bit each, the level vehicle-demand sensors.
REQ-009 The block SHALL have port ped_req, input, 1 bit, the pedestrian button (any-length pulse).
REQ-010 The block SHALL have ports RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE and GREEN_WE, output, 1 bit each, the lamp drives.
REQ-011 The block SHALL have port WALK, output, 1 bit, the pedestrian walk lamp.
REQ-012 The block SHALL have port ped_pending, output, 1 bit, a latched pedestrian request not yet served.

Function
REQ-013 The state set SHALL be exactly ALL_RED, NS_GREEN, NS_YELLOW, WE_GREEN, WE_YELLOW, PED_WALK.
REQ-014 The block SHALL hold an 8-bit cycle timer, cleared on every state entry; all parameters SHALL be 1..255, with MIN_GREEN <= MAX_GREEN.
REQ-015 The block SHALL hold a last_dir register (NS/WE) recording the most recently served green direction.
REQ-016 Outputs SHALL be a Moore decode of the state register, with no extra register stage.
- Green state: own GREEN=1, other RED=1.
- Yellow state: own YELLOW=1, other RED=1.
- ALL_RED and PED_WALK: both REDs=1.
- WALK=1 only in PED_WALK.
- Exactly one lamp per direction is lit in every state.
REQ-017 In a green state, the timer SHALL increment each cycle and saturate at MAX_GREEN-1.
REQ-018 Green SHALL exit to its yellow state when all of the following hold:
- timer >= MIN_GREEN-1;
- (opposing req | ped_pending) = 1;
- (own req = 0 | timer = MAX_GREEN-1).
REQ-019 With no opposing demand and no ped_pending, green SHALL hold indefinitely.
REQ-020 Yellow SHALL last exactly YELLOW_T cycles, then go to ALL_RED.
REQ-021 ALL_RED SHALL last exactly ALL_RED_T cycles, then exit as follows:
- ped_pending=1: go to PED_WALK;
- otherwise: go to the green opposite last_dir.
REQ-022 PED_WALK SHALL last exactly WALK_T cycles, then go to the green opposite last_dir.
REQ-023 last_dir SHALL update on entry to NS_GREEN or WE_GREEN.
REQ-024 ped_pending SHALL set on any cycle ped_req=1 and clear on the edge entering PED_WALK.
- ped_req=1 on that same edge is considered served (clear wins).
- ped_req=1 during PED_WALK re-sets ped_pending.
REQ-025 An opposing request that drops before the green exits SHALL not force a phase change.

Reset
REQ-026 clear_n=0 SHALL immediately, without waiting for clk, force the following:
- state=ALL_RED, timer=0, last_dir=WE, ped_pending=0;
- RED_NS=RED_WE=1 and all other lamps 0;
- WALK=0.
REQ-027 After clear_n rises, the first green served SHALL be NS_GREEN, after ALL_RED_T cycles.
REQ-028 Reset asserted mid-phase (including during yellow or PED_WALK) SHALL abandon the phase with no partial completion.

Verification (defaults)
REQ-029 The bench SHALL cover reset release with no requests -> all-red for 2 cycles, then NS green held for 100+ cycles.
REQ-030 The bench SHALL cover NS green, req_we=1 at cycle 0, req_ns=0 -> GREEN_NS for exactly 10 cycles, then YELLOW_NS 4, all-red 2, then GREEN_WE.
REQ-031 The bench SHALL cover req_ns and req_we both held high -> NS green exactly 30 cycles, yellow 4, all-red 2, WE green 30, with alternation repeating.
REQ-032 The bench SHALL cover a 1-cycle ped_req pulse during WE green with no vehicle demand -> ped_pending=1, then green ends at MIN_GREEN, then yellow 4, all-red 2, WALK 8, then NS green with ped_pending=0.
REQ-033 The bench SHALL cover clear_n asserted mid-yellow, asynchronously between edges -> all-red lamps and WALK=0 before the next clk edge, with ped_pending cleared.
REQ-034 The bench SHALL cover ped_req held during PED_WALK -> a second walk after the next green completes; every cycle checks exactly one lamp lit per direction.
